// File: rtl/logic_out_filter.sv
// logic_out_filter: synchronizes and debounces a glitchy async level, emitting edge pulses and event counts
module logic_out_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CYCLES = 4,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             y_in,
   input  logic             cnt_clr,
   output logic             y_filt,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic [CNT_W-1:0] rise_count,
   output logic [CNT_W-1:0] fall_count,
   output logic [CNT_W-1:0] glitch_count
);
   localparam int CW = $clog2(FILT_CYCLES + 1);
   localparam logic [CW-1:0] FILT_N = CW'(FILT_CYCLES);

   typedef enum logic [1:0] {LOW, CONF_H, HIGH, CONF_L} state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   y_sync;
   state_t                 state, state_nx;
   logic [CW-1:0]          ccnt, ccnt_nx, ccnt_inc;
   logic                   rise_ev, fall_ev, glitch_ev;

   assign y_sync = sync_q[SYNC_STAGES-1];

   // Saturating counter step; a clear coinciding with an event keeps that event.
   function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c, input logic ev, input logic clr);
      return clr ? (ev ? CNT_W'(1) : '0) : (ev && c != '1) ? c + CNT_W'(1) : c;
   endfunction

   // Shift the raw input through the synchronizer chain.
   always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], y_in};
   end

   // State and confirm-counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= LOW;
         ccnt  <= '0;
      end else begin
         state <= state_nx;
         ccnt  <= ccnt_nx;
      end
   end

   // Debounce decisions: confirm a new level for FILT_CYCLES samples, abort on any reversal.
   always_comb begin
      state_nx  = state;
      ccnt_nx   = ccnt;
      rise_ev   = 1'b0;
      fall_ev   = 1'b0;
      glitch_ev = 1'b0;
      ccnt_inc  = ccnt + CW'(1);
      case (state)
         LOW: if (y_sync) begin
            if (FILT_CYCLES == 1) begin
               state_nx = HIGH;
               rise_ev  = 1'b1;
               ccnt_nx  = '0;
            end else begin
               state_nx = CONF_H;
               ccnt_nx  = CW'(1);
            end
         end
         CONF_H: if (!y_sync) begin
            state_nx  = LOW;
            ccnt_nx   = '0;
            glitch_ev = 1'b1;
         end else if (ccnt_inc == FILT_N) begin
            state_nx = HIGH;
            ccnt_nx  = '0;
            rise_ev  = 1'b1;
         end else begin
            ccnt_nx = ccnt_inc;
         end
         HIGH: if (!y_sync) begin
            if (FILT_CYCLES == 1) begin
               state_nx = LOW;
               fall_ev  = 1'b1;
               ccnt_nx  = '0;
            end else begin
               state_nx = CONF_L;
               ccnt_nx  = CW'(1);
            end
         end
         CONF_L: if (y_sync) begin
            state_nx  = HIGH;
            ccnt_nx   = '0;
            glitch_ev = 1'b1;
         end else if (ccnt_inc == FILT_N) begin
            state_nx = LOW;
            ccnt_nx  = '0;
            fall_ev  = 1'b1;
         end else begin
            ccnt_nx = ccnt_inc;
         end
         default: begin
            state_nx = LOW;
            ccnt_nx  = '0;
         end
      endcase
   end

   // Register the filtered level, edge pulses and event counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         y_filt       <= 1'b0;
         rise_pulse   <= 1'b0;
         fall_pulse   <= 1'b0;
         rise_count   <= '0;
         fall_count   <= '0;
         glitch_count <= '0;
      end else begin
         y_filt       <= rise_ev ? 1'b1 : fall_ev ? 1'b0 : y_filt;
         rise_pulse   <= rise_ev;
         fall_pulse   <= fall_ev;
         rise_count   <= cnt_step(rise_count, rise_ev, cnt_clr);
         fall_count   <= cnt_step(fall_count, fall_ev, cnt_clr);
         glitch_count <= cnt_step(glitch_count, glitch_ev, cnt_clr);
      end
   end
endmodule

// File: tb/tb_logic_out_filter.sv
// tb_logic_out_filter: directed table-driven checks of the debounce filter
module tb_logic_out_filter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, y_in, cnt_clr, y_filt, rise_pulse, fall_pulse;
   logic [7:0] rise_count, fall_count, glitch_count;
   logic y2, clr2, y_filt2, rise_pulse2, fall_pulse2;
   logic [1:0] rise_count2, fall_count2, glitch_count2;

   logic_out_filter dut (
      .clk(clk), .rst(rst), .y_in(y_in), .cnt_clr(cnt_clr),
      .y_filt(y_filt), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
      .rise_count(rise_count), .fall_count(fall_count), .glitch_count(glitch_count)
   );

   logic_out_filter #(.SYNC_STAGES(2), .FILT_CYCLES(1), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .y_in(y2), .cnt_clr(clr2),
      .y_filt(y_filt2), .rise_pulse(rise_pulse2), .fall_pulse(fall_pulse2),
      .rise_count(rise_count2), .fall_count(fall_count2), .glitch_count(glitch_count2)
   );

   int errors = 0, checks = 0;
   int n_rise = 0, n_fall = 0, n_rise2 = 0, n_fall2 = 0;

   // Count pulse cycles away from the active edge.
   always @(negedge clk) begin
      if (rise_pulse)  n_rise++;
      if (fall_pulse)  n_fall++;
      if (rise_pulse2) n_rise2++;
      if (fall_pulse2) n_fall2++;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   typedef struct {
      int hi1, dip, hi2, dr, df, dg;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int er, ef, eg, r0, f0, nh;
      tbl = '{
         '{3, 0, 0, 0, 0, 1},
         '{4, 0, 0, 1, 1, 0},
         '{1, 0, 0, 0, 0, 1},
         '{10, 2, 10, 1, 1, 1},
         '{2, 1, 2, 0, 0, 2},
         '{2, 1, 4, 1, 1, 1}
      };
      rst = 1'b1; y_in = 1'b0; cnt_clr = 1'b0; y2 = 1'b0; clr2 = 1'b0;
      tick(2);
      rst = 1'b0;
      chk("reset_y_filt", y_filt, 0);
      chk("reset_rise_pulse", rise_pulse, 0);
      chk("reset_fall_pulse", fall_pulse, 0);
      chk("reset_rise_count", rise_count, 0);
      chk("reset_fall_count", fall_count, 0);
      chk("reset_glitch_count", glitch_count, 0);
      y_in = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         tick(1);
         chk($sformatf("rise_lat_pulse_e%0d", e), rise_pulse, int'(e == 6));
         chk($sformatf("rise_lat_filt_e%0d", e), y_filt, int'(e >= 6));
      end
      chk("rise_lat_count", rise_count, 1);
      chk("rise_lat_glitch", glitch_count, 0);
      y_in = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         tick(1);
         chk($sformatf("fall_lat_pulse_e%0d", e), fall_pulse, int'(e == 6));
         chk($sformatf("fall_lat_filt_e%0d", e), y_filt, int'(e < 6));
      end
      chk("fall_lat_count", fall_count, 1);
      cnt_clr = 1'b1;
      tick(1);
      cnt_clr = 1'b0;
      chk("clr0_rise", rise_count, 0);
      chk("clr0_fall", fall_count, 0);
      er = 0; ef = 0; eg = 0;
      for (int i = 0; i < 6; i++) begin
         r0 = n_rise; f0 = n_fall;
         y_in = 1'b1; tick(tbl[i].hi1);
         if (tbl[i].dip > 0) begin
            y_in = 1'b0; tick(tbl[i].dip);
            y_in = 1'b1; tick(tbl[i].hi2);
         end
         y_in = 1'b0; tick(12);
         er += tbl[i].dr; ef += tbl[i].df; eg += tbl[i].dg;
         chk($sformatf("vec%0d_rise_count", i), rise_count, er);
         chk($sformatf("vec%0d_fall_count", i), fall_count, ef);
         chk($sformatf("vec%0d_glitch_count", i), glitch_count, eg);
         chk($sformatf("vec%0d_y_filt", i), y_filt, 0);
         chk($sformatf("vec%0d_rise_pulses", i), n_rise - r0, tbl[i].dr);
         chk($sformatf("vec%0d_fall_pulses", i), n_fall - f0, tbl[i].df);
      end
      cnt_clr = 1'b1;
      tick(1);
      cnt_clr = 1'b0;
      chk("clr1_rise", rise_count, 0);
      chk("clr1_glitch", glitch_count, 0);
      for (int i = 0; i < 5; i++) begin
         y_in = 1'b1; tick(6);
         y_in = 1'b0; tick(10);
      end
      chk("five_rise_count", rise_count, 5);
      chk("five_fall_count", fall_count, 5);
      y_in = 1'b1;
      tick(5);
      cnt_clr = 1'b1;
      tick(1);
      cnt_clr = 1'b0;
      chk("clr_event_rise_count", rise_count, 1);
      chk("clr_event_fall_count", fall_count, 0);
      chk("clr_event_pulse", rise_pulse, 1);
      chk("clr_event_y_filt", y_filt, 1);
      cnt_clr = 1'b1;
      tick(1);
      cnt_clr = 1'b0;
      chk("clr_alone_rise_count", rise_count, 0);
      chk("clr_alone_y_filt", y_filt, 1);
      y_in = 1'b0; tick(12);
      chk("after_clr_fall_count", fall_count, 1);
      y_in = 1'b1;
      tick(4);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("midrst_y_filt", y_filt, 0);
      chk("midrst_rise_count", rise_count, 0);
      chk("midrst_fall_count", fall_count, 0);
      chk("midrst_glitch_count", glitch_count, 0);
      for (int e = 1; e <= 6; e++) begin
         tick(1);
         chk($sformatf("midrst_lat_e%0d", e), rise_pulse, int'(e == 6));
      end
      chk("midrst_glitch_after", glitch_count, 0);
      chk("midrst_rise_after", rise_count, 1);
      y_in = 1'b0; tick(12);
      r0 = n_rise; f0 = n_fall; nh = 0;
      for (int i = 0; i < 50; i++) begin
         y_in = (i % 2 == 0);
         if (y_in) nh++;
         tick(1);
      end
      y_in = 1'b0; tick(12);
      chk("toggle_glitch_count", glitch_count, nh);
      chk("toggle_rise_pulses", n_rise - r0, 0);
      chk("toggle_fall_pulses", n_fall - f0, 0);
      chk("toggle_y_filt", y_filt, 0);
      for (int i = 0; i < 5; i++) begin
         y2 = 1'b1; tick(4);
         y2 = 1'b0; tick(4);
      end
      tick(6);
      chk("sat_rise_count", rise_count2, 3);
      chk("sat_fall_count", fall_count2, 3);
      chk("sat_glitch_count", glitch_count2, 0);
      chk("sat_rise_pulses", n_rise2, 5);
      chk("sat_fall_pulses", n_fall2, 5);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
